counter_up_8bit_mod: RTL and testbench
======================================

Name: counter_up_8bit_mod

Overview:
- 8-bit up counter with programmable terminal value, synchronous load, and free-run or one-shot mode.
- Counterpart to the team's 8-bit down counter: counts 0 -> limit instead of 255 -> 0.
- Run control is a small FSM (IDLE/RUN/DONE). Outputs a registered terminal-count pulse and a saturating wrap counter.
- Used as a timebase / event counter next to the down counter in the BEGIN counter blocks.

Parameters:
- WIDTH, 8, counter/limit/load width (all values below assume 8)
- WRAP_W, 8, width of wrap_cnt

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset (sampled on rising clk edge while 0)
- enable  input  1  increment qualifier; counts only in RUN while high
- start  input  1  level-sampled; IDLE->RUN, or DONE->RUN with count cleared
- load  input  1  synchronous load of load_val; priority over increment
- load_val  input  8  value written on load (clamped to limit)
- limit  input  8  terminal value; sampled every cycle, not latched
- one_shot  input  1  1: stop at limit (DONE); 0: wrap to 0 and continue
- count  output  8  current count (registered)
- tc  output  1  one-cycle pulse on the edge count reaches terminal (wrap or stop)
- done  output  1  high while in DONE
- busy  output  1  high while in RUN
- wrap_cnt  output  8  number of wraps since reset/start-from-DONE; saturates at 255

Behaviour:
- Reset (reset==0 at edge): state=IDLE, count=0, tc=0, done=0, busy=0, wrap_cnt=0. Reset overrides every other input, including mid-RUN.
- All outputs are registered. Output changes are visible the cycle after the inputs are sampled.
- IDLE: count holds; enable ignored. start=1 -> RUN (count unchanged). load=1 -> count=min(load_val,limit). start+load together -> RUN with the loaded value.
- RUN, per edge, in priority order:
  1. load=1 -> count=min(load_val,limit), tc=0, stay RUN.
  2. enable=1 and count>=limit:
     - one_shot=0: count=0, tc=1, wrap_cnt+=1 (saturating at 255), stay RUN.
     - one_shot=1: count=limit, tc=1, state=DONE.
  3. enable=1 and count<limit -> count+1, tc=0.
  4. enable=0 -> hold count, tc=0.
  - start is ignored in RUN.
- The terminal comparison is >=, so lowering limit below count mid-run terminates on the next enabled cycle.
- limit=0: every enabled cycle is terminal. Free-run gives tc high continuously and count stays 0. One-shot goes to DONE on the first enabled cycle.
- DONE: count holds at limit value reached; done=1, busy=0.
  - start=1 -> count=0, wrap_cnt=0, RUN.
  - load=1 (without start) -> count=min(load_val,limit), IDLE.
  - start+load -> count=min(load_val,limit), wrap_cnt=0, RUN.
- tc is high for exactly one cycle per terminal event, except the limit=0 free-run case. tc is never high outside the cycle following a terminal increment.
- busy and done are mutually exclusive. Both are 0 in IDLE.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: hold reset=0 for 2 cycles with start=1, enable=1 -> count=0, tc=0, busy=0, done=0, wrap_cnt=0 throughout.
- Free-run wrap: limit=5, one_shot=0, start then enable=1 for 14 cycles -> count 0,1,2,3,4,5,0,1,…; tc high on both 5->0 edges; wrap_cnt=2.
- One-shot: limit=3, one_shot=1, enable=1 -> count 1,2,3, then DONE; done=1, tc single pulse, count stays 3 for 5 more cycles. Then start -> count=0, busy=1.
- Enable gating and load: RUN, count=4, enable=0 for 3 cycles -> count stays 4. Then load=1, load_val=200, limit=100 -> count=100 (clamped). Next enabled cycle -> wrap to 0, tc=1.
- Reset mid-operation: in RUN at count=7, drive reset=0 for one edge -> count=0, IDLE, busy=0. After release, enable alone does not count until start.
- Boundaries: limit=0 free-run -> count=0, tc=1 every enabled cycle. Run 300 wraps with limit=0 -> wrap_cnt saturates at 255.

Source files
------------

// File: rtl/counter_up_8bit_mod.sv
// counter_up_8bit_mod
// Up counter (0 -> limit) with programmable terminal value, synchronous
// clamped load, and free-run or one-shot operation. A three-state FSM
// (IDLE / RUN / DONE) gates counting. tc is a registered one-cycle
// terminal pulse, and wrap_cnt is a saturating count of free-run wraps.
// Every output comes straight from a flop, so no input reaches an output
// combinationally.

module counter_up_8bit_mod #(
  parameter int WIDTH  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,     // synchronous, active-low
  input  logic              enable,
  input  logic              start,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  limit,
  input  logic              one_shot,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              done,
  output logic              busy,
  output logic [WRAP_W-1:0] wrap_cnt
);

  // Run-control states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [WRAP_W-1:0] WRAP_ONE = 1;
  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              tc_q, tc_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;

  // A load never places the counter beyond the current terminal value.
  logic [WIDTH-1:0]  load_clamped;
  logic              at_terminal;
  logic [WRAP_W-1:0] wrap_inc;

  // Shared helper terms: clamped load value, terminal test, saturating wrap
  always_comb begin
    load_clamped = (load_val > limit) ? limit : load_val;
    // >= rather than == so lowering limit below count ends the run promptly.
    at_terminal  = (count_q >= limit);
    wrap_inc     = (wrap_q == WRAP_MAX) ? wrap_q : (wrap_q + WRAP_ONE);
  end

  // Next-state logic for the FSM, counter, terminal pulse and wrap counter
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
    wrap_d  = wrap_q;

    unique case (state_q)
      ST_IDLE: begin
        // enable is ignored while idle; start and load may combine.
        if (load) begin
          count_d = load_clamped;
        end
        if (start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // start has no effect while running.
        if (load) begin
          count_d = load_clamped;
        end else if (enable) begin
          if (at_terminal) begin
            tc_d = 1'b1;
            if (one_shot) begin
              count_d = limit;
              state_d = ST_DONE;
            end else begin
              count_d = '0;
              wrap_d  = wrap_inc;
            end
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
      end

      ST_DONE: begin
        if (start) begin
          // Restarting from DONE begins a fresh wrap history.
          state_d = ST_RUN;
          wrap_d  = '0;
          count_d = load ? load_clamped : '0;
        end else if (load) begin
          state_d = ST_IDLE;
          count_d = load_clamped;
        end
      end

      default: begin
        // Unreachable encoding: recover to a safe idle state.
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the upcoming state.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values;
    // the reset lives inside the clocked branch, making it synchronous.
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count    = count_q;
  assign tc       = tc_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign wrap_cnt = wrap_q;

endmodule

// File: tb/tb_counter_up_8bit_mod.sv
// Directed testbench for counter_up_8bit_mod. Inputs change 1 ns after a
// rising edge; outputs are checked at that same point, away from the edge.

module tb_counter_up_8bit_mod;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       start;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] limit;
  logic       one_shot;
  logic [7:0] count;
  logic       tc;
  logic       done;
  logic       busy;
  logic [7:0] wrap_cnt;

  int checks = 0;
  int errors = 0;

  counter_up_8bit_mod #(.WIDTH(8), .WRAP_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .start    (start),
    .load     (load),
    .load_val (load_val),
    .limit    (limit),
    .one_shot (one_shot),
    .count    (count),
    .tc       (tc),
    .done     (done),
    .busy     (busy),
    .wrap_cnt (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_cnt, input logic e_tc,
                           input logic e_busy, input logic e_done, input logic [7:0] e_wrap);
    check({tag, ".count"}, count, e_cnt);
    check_bit({tag, ".tc"}, tc, e_tc);
    check_bit({tag, ".busy"}, busy, e_busy);
    check_bit({tag, ".done"}, done, e_done);
    check({tag, ".wrap"}, wrap_cnt, e_wrap);
  endtask

  initial begin
    logic [7:0] exp_cnt;
    logic [7:0] exp_wrap;
    logic       exp_tc;

    reset = 1'b0; enable = 1'b1; start = 1'b1; load = 1'b0;
    load_val = 8'd0; limit = 8'd5; one_shot = 1'b0;

    // Reset held for two edges with start/enable asserted
    tick(); check_all("reset1", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    tick(); check_all("reset2", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Release: idle, enable alone does nothing
    reset = 1'b1; start = 1'b0; enable = 1'b1;
    tick(); check_all("idle", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Free-run wrap, limit = 5
    start = 1'b1; enable = 1'b0;
    tick(); check_all("start", 8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    start = 1'b0; enable = 1'b1;
    exp_cnt = 8'd0; exp_wrap = 8'd0;
    for (int i = 0; i < 14; i++) begin
      exp_tc  = (exp_cnt >= 8'd5);
      exp_cnt = exp_tc ? 8'd0 : exp_cnt + 8'd1;
      if (exp_tc) exp_wrap = exp_wrap + 8'd1;
      tick(); check_all("freerun", exp_cnt, exp_tc, 1'b1, 1'b0, exp_wrap);
    end
    check("freerun_final_wrap", wrap_cnt, 8'd2);
    check("freerun_final_cnt", count, 8'd2);

    // Enable gating
    tick(); tick(); check("gate_pre", count, 8'd4);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("gate_hold", 8'd4, 1'b0, 1'b1, 1'b0, 8'd2);
    end

    // Clamped load then wrap from the new limit
    load = 1'b1; load_val = 8'd200; limit = 8'd100;
    tick(); check_all("load_clamp", 8'd100, 1'b0, 1'b1, 1'b0, 8'd2);
    load = 1'b0; enable = 1'b1;
    tick(); check_all("load_wrap", 8'd0, 1'b1, 1'b1, 1'b0, 8'd3);
    tick(); check_all("post_wrap", 8'd1, 1'b0, 1'b1, 1'b0, 8'd3);

    // Reset mid-run at count 7
    for (int i = 0; i < 6; i++) tick();
    check("pre_reset_cnt", count, 8'd7);
    reset = 1'b0;
    tick(); check_all("midrun_reset", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_all("post_reset_idle", 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // One-shot with limit = 3
    limit = 8'd3; one_shot = 1'b1; start = 1'b1; enable = 1'b0;
    tick(); check_all("os_start", 8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    start = 1'b0; enable = 1'b1;
    tick(); check_all("os_c1", 8'd1, 1'b0, 1'b1, 1'b0, 8'd0);
    tick(); check_all("os_c2", 8'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    tick(); check_all("os_c3", 8'd3, 1'b0, 1'b1, 1'b0, 8'd0);
    tick(); check_all("os_done", 8'd3, 1'b1, 1'b0, 1'b1, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick(); check_all("os_hold", 8'd3, 1'b0, 1'b0, 1'b1, 8'd0);
    end
    start = 1'b1;
    tick(); check_all("os_restart", 8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
    start = 1'b0;

    // Back to DONE, then load (no start) returns to IDLE
    for (int i = 0; i < 4; i++) tick();
    check_bit("os2_done", done, 1'b1);
    load = 1'b1; load_val = 8'd2;
    tick(); check_all("done_load_idle", 8'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    load = 1'b0;

    // Lowering limit below count terminates on the next enabled cycle
    start = 1'b1; one_shot = 1'b0;
    tick(); check_all("idle_to_run", 8'd2, 1'b0, 1'b1, 1'b0, 8'd0);
    start = 1'b0; limit = 8'd1;
    tick(); check_all("limit_lowered", 8'd0, 1'b1, 1'b1, 1'b0, 8'd1);

    // limit = 0 free-run: tc every cycle, wrap_cnt saturates at 255
    limit = 8'd0;
    exp_wrap = 8'd1;
    for (int i = 0; i < 300; i++) begin
      if (exp_wrap != 8'd255) exp_wrap = exp_wrap + 8'd1;
      tick(); check_all("lim0", 8'd0, 1'b1, 1'b1, 1'b0, exp_wrap);
    end
    check("lim0_sat", wrap_cnt, 8'd255);

    // limit = 0 one-shot: DONE on the first enabled cycle
    one_shot = 1'b1;
    tick(); check_all("lim0_os", 8'd0, 1'b1, 1'b0, 1'b1, 8'd255);
    tick(); check_all("lim0_os_hold", 8'd0, 1'b0, 1'b0, 1'b1, 8'd255);

    // start+load from DONE: loaded value, wrap cleared
    start = 1'b1; load = 1'b1; load_val = 8'd9; limit = 8'd50;
    tick(); check_all("done_start_load", 8'd9, 1'b0, 1'b1, 1'b0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
